t_pulse_gen: RTL
================

Name: t_pulse_gen

Overview:
Upstream stage of the T flip-flop. Converts a raw, bouncy, asynchronous push-button level into a clean single-cycle toggle-enable pulse `t`, which drives the flip-flop's `t` input on the same `ck`. Contains a two-flop synchroniser, a debounce FSM with a counter, and a rising-edge pulse generator. Also exports the debounced level for status use.

Parameters:
DB_CYCLES, 4, consecutive cycles the synchronised input must stay at a new level before that level is accepted (legal range 1..2**CNT_W-1)
CNT_W, 8, width of the debounce counter
REPEAT_CYCLES, 16, auto-repeat interval in cycles; used only when AUTO_REPEAT_EN is defined

Ports:
ck  in  1  clock; all logic on rising edge
rs  in  1  reset, synchronous, active-high
btn  in  1  raw button level, asynchronous to ck
t  out  1  toggle-enable pulse, high for exactly one ck cycle per accepted press
btn_db  out  1  debounced button level
busy  out  1  high while a level change is being qualified

Behaviour:
- Reset (rs=1 at a ck edge): sync flops=0, state=IDLE, cnt=0, t=0, btn_db=0, busy=0. Reset dominates every other event. A pulse in flight is dropped.
- Synchroniser: s1<=btn, s2<=s1. `btn_s`=s2.
- FSM states: IDLE (stable low), WAIT_HI, HIGH (stable high), WAIT_LO. cnt is cleared on every state change.
- IDLE: if btn_s=1, go to WAIT_HI.
- WAIT_HI:
  - If btn_s=0, go to IDLE (glitch rejected, no pulse).
  - Else if cnt==DB_CYCLES-1, go to HIGH with btn_db<=1 and t<=1.
  - Else cnt<=cnt+1.
- HIGH: t<=0 (unless auto-repeat fires). If btn_s=0, go to WAIT_LO.
- WAIT_LO:
  - If btn_s=1, go to HIGH (no pulse).
  - Else if cnt==DB_CYCLES-1, go to IDLE with btn_db<=0.
  - Else cnt++.
  - Release never generates t.
- Latency: let E0 be the first edge where s1 captures 1 and btn stays high. Then `t`=1 and `btn_db`=1 during the cycle after edge E0+DB_CYCLES+2. With DB_CYCLES=4, that is after E6.
- busy=1 exactly while in WAIT_HI or WAIT_LO (registered with state).
- t is registered and never high for two consecutive cycles, except through auto-repeat when REPEAT_CYCLES=1.
- cnt must never wrap; the counter is sized so that DB_CYCLES-1 fits in CNT_W.
- btn held high through reset release: treated as a fresh press; one pulse after the normal debounce latency.
- DB_CYCLES=1: a level is accepted on the first WAIT cycle (one-sample confirmation).

Optional Feature:
Macro: T_PULSE_GEN_AUTO_REPEAT_EN.
- Defined:
  - In HIGH, a repeat counter (width sized for REPEAT_CYCLES) increments each cycle.
  - When it reaches REPEAT_CYCLES-1, t<=1 for one cycle and the counter clears.
  - The counter clears on every entry to HIGH, including re-entry from WAIT_LO.
  - The counter holds while in WAIT_LO.
- Undefined: no repeat counter exists; exactly one pulse per accepted press regardless of hold time.

Decomposition:
- Shared package t_pulse_gen_pkg: state encoding constants (IDLE=2'd0, WAIT_HI=2'd1, HIGH=2'd2, WAIT_LO=2'd3) and default DB_CYCLES/REPEAT_CYCLES constants.
- One sub-module: sync2 (two-flop synchroniser, ck/rs/d/q, reset to 0), reusable elsewhere.
- FSM, counters and pulse logic stay in t_pulse_gen.

Test Plan:
Bench: ck period 100, DB_CYCLES=4, REPEAT_CYCLES=16, t_pulse_gen.t driving the downstream T flip-flop.
- Clean press: btn 0->1 held 20 cycles -> t=1 for exactly one cycle, 6 edges after first s1 capture; btn_db 0->1 on the same cycle; flip-flop q toggles once.
- Bounce rejection: btn high 2 cycles, low 1, high 2, low -> no t pulse; btn_db stays 0; busy pulses; q unchanged.
- Release: after an accepted press, btn->0 held 10 cycles -> btn_db->0 after 6 edges; t stays 0.
- Release glitch: in HIGH, btn low for 2 cycles then high -> FSM returns to HIGH; no pulse; btn_db stays 1.
- Reset mid-qualify: assert rs for 1 cycle while in WAIT_HI, btn held high -> t=0, btn_db=0 during reset; then exactly one pulse after a full new debounce latency.
- Auto-repeat (macro defined): btn held 60 cycles -> initial pulse, then pulses every 16 cycles (4 pulses total); macro undefined -> 1 pulse.

Source files
------------

// File: rtl/t_pulse_gen_pkg.sv
// t_pulse_gen_pkg: shared state encoding and default timing constants for t_pulse_gen
package t_pulse_gen_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } state_t;
  localparam int DEF_DB_CYCLES     = 4;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_REPEAT_CYCLES = 16;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for an asynchronous level, reset to 0
module sync2 (
  input  logic ck,
  input  logic rs,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge ck) begin
    if (rs) {q, s1} <= 2'b00;
    else    {q, s1} <= {s1, d};
  end
endmodule

// File: rtl/t_pulse_gen.sv
// t_pulse_gen: debounced single-cycle toggle pulse from a raw button; T_PULSE_GEN_AUTO_REPEAT_EN adds hold-to-repeat
module t_pulse_gen
  import t_pulse_gen_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
  , parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
`endif
) (
  input  logic ck,
  input  logic rs,
  input  logic btn,
  output logic t,
  output logic btn_db,
  output logic busy
);
  logic btn_s;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic last;
  sync2 u_sync (.ck(ck), .rs(rs), .d(btn), .q(btn_s));
  assign last = cnt == CNT_W'(DB_CYCLES - 1);
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
  localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
  logic [RW-1:0] rep;
  logic rep_hit;
  assign rep_hit = rep == RW'(REPEAT_CYCLES - 1);
`endif
  always_ff @(posedge ck) begin
    if (rs) begin
      state  <= IDLE;
      cnt    <= '0;
      t      <= 1'b0;
      btn_db <= 1'b0;
      busy   <= 1'b0;
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
      rep    <= '0;
`endif
    end else begin
      t <= 1'b0;
      case (state)
        IDLE: if (btn_s) begin
          state <= WAIT_HI;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        WAIT_HI: if (!btn_s) begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end else if (last) begin
          state  <= HIGH;
          cnt    <= '0;
          busy   <= 1'b0;
          btn_db <= 1'b1;
          t      <= 1'b1;
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
          rep    <= '0;
`endif
        end else cnt <= cnt + 1'b1;
        HIGH: begin
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
          rep <= rep_hit ? '0 : rep + 1'b1;
          t   <= rep_hit;
`endif
          if (!btn_s) begin
            state <= WAIT_LO;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_LO: if (btn_s) begin
          state <= HIGH;
          cnt   <= '0;
          busy  <= 1'b0;
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
          rep   <= '0;
`endif
        end else if (last) begin
          state  <= IDLE;
          cnt    <= '0;
          busy   <= 1'b0;
          btn_db <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
